// File: rtl/msg_fifo_stream_reg_pkg.sv
// Shared constants for the pixel-stream register slice and the bounding-box message FIFO.
package msg_fifo_stream_reg_pkg;

  localparam int DATA_WIDTH_DEF = 26;
  localparam int MSG_WIDTH      = 32;
  localparam int MSG_DEPTH      = 256;
  localparam int USEDW_W        = 8;

  // Tag carried in the first word of every bounding-box message ("RBB").
  localparam logic [23:0] MSG_ID_RBB = 24'h524242;

endpackage

// File: rtl/msg_fifo_stream_reg_if.sv
// Bundles the pixel-stream handshake and the CPU-side message FIFO port.
interface msg_fifo_stream_reg_if
  import msg_fifo_stream_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready_out;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready_in;

  logic [MSG_WIDTH-1:0]  msg_data;
  logic                  msg_wrreq;
  logic                  msg_rdreq;
  logic                  msg_sclr;
  logic [MSG_WIDTH-1:0]  msg_q;
  logic [USEDW_W-1:0]    msg_usedw;
  logic                  msg_empty;
  logic                  msg_full;

  modport slave (
    input  valid_in, data_in, ready_in,
    input  msg_data, msg_wrreq, msg_rdreq, msg_sclr,
    output ready_out, valid_out, data_out,
    output msg_q, msg_usedw, msg_empty, msg_full
  );

  modport master (
    output valid_in, data_in, ready_in,
    output msg_data, msg_wrreq, msg_rdreq, msg_sclr,
    input  ready_out, valid_out, data_out,
    input  msg_q, msg_usedw, msg_empty, msg_full
  );

endinterface

// File: rtl/msg_fifo_stream_reg_slice.sv
// One-stage valid/ready register slice with a skid buffer; o_ready is fully registered.
module stream_reg_slice
  import msg_fifo_stream_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_skid_v;
  logic [DATA_WIDTH-1:0] r_skid_d;
  logic                  w_accept;

  assign w_accept = i_valid & ~r_skid_v;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else if (r_skid_v) begin
      // Skid only ever fills while main is holding, so main is valid here.
      if (i_ready) begin
        r_data   <= r_skid_d;
        r_valid  <= 1'b1;
        r_skid_v <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_valid || i_ready) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else begin
        r_skid_d <= i_data;
        r_skid_v <= 1'b1;
      end
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready = ~r_skid_v;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/msg_fifo_stream_reg.sv
// Pixel-stream retiming slice plus a show-ahead message FIFO read by the CPU.
module msg_fifo_stream_reg
  import msg_fifo_stream_reg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  msg_fifo_stream_reg_if.slave   bus
);

  stream_reg_slice #(
    .DATA_WIDTH (DATA_WIDTH_DEF)
  ) u_slice (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (bus.valid_in),
    .i_data  (bus.data_in),
    .o_ready (bus.ready_out),
    .o_valid (bus.valid_out),
    .o_data  (bus.data_out),
    .i_ready (bus.ready_in)
  );

  localparam logic [USEDW_W:0] CNT_FULL = (USEDW_W+1)'(MSG_DEPTH);

  logic [MSG_WIDTH-1:0] r_mem [MSG_DEPTH];
  logic [USEDW_W-1:0]   r_rd_ptr;
  logic [USEDW_W-1:0]   r_wr_ptr;
  logic [USEDW_W:0]     r_count;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_clr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_wr    = bus.msg_wrreq & ~w_full;
  assign w_rd    = bus.msg_rdreq & ~w_empty;
  assign w_clr   = ~reset_n | bus.msg_sclr;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the clear only rewinds pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr && !w_clr) r_mem[r_wr_ptr] <= bus.msg_data;
  end

  assign bus.msg_q     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.msg_usedw = r_count[USEDW_W-1:0];
  assign bus.msg_empty = w_empty;
  assign bus.msg_full  = w_full;

endmodule

// File: tb/tb_msg_fifo_stream_reg.sv
// Scoreboard bench for the stream slice and the message FIFO.
module tb_msg_fifo_stream_reg;
  import msg_fifo_stream_reg_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  msg_fifo_stream_reg_if bus ();

  msg_fifo_stream_reg dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_WIDTH_DEF-1:0] sb [$];
  logic [MSG_WIDTH-1:0]      mq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transfers are decided by the values visible at the falling edge before the next rising edge.
  logic                      prev_stall = 1'b0;
  logic [DATA_WIDTH_DEF-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 32'(bus.data_out), 32'(prev_data));
      if (bus.valid_in && bus.ready_out) sb.push_back(bus.data_in);
      if (bus.valid_out && bus.ready_in) begin
        if (sb.size() == 0) chk("stream_extra_beat", 32'd1, 32'd0);
        else                chk("stream_data", 32'(bus.data_out), 32'(sb.pop_front()));
      end
      prev_stall = bus.valid_out & ~bus.ready_in;
      prev_data  = bus.data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n       = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.ready_in  = 1'b0;
    bus.msg_wrreq = 1'b0;
    bus.msg_rdreq = 1'b0;
    bus.msg_sclr  = 1'b0;
    bus.msg_data  = '0;
    repeat (cycles) tick();
    reset_n = 1'b1;
    sb.delete();
    mq.delete();
  endtask

  task automatic check_fifo();
    chk("msg_q", bus.msg_q, (mq.size() == 0) ? 32'd0 : mq[0]);
    chk("msg_usedw", 32'(bus.msg_usedw), 32'(mq.size() % MSG_DEPTH));
    chk("msg_empty", 32'(bus.msg_empty), 32'(mq.size() == 0));
    chk("msg_full", 32'(bus.msg_full), 32'(mq.size() == MSG_DEPTH));
  endtask

  task automatic msg_cycle(input logic wr, input logic rd, input logic sclr, input logic [31:0] d);
    bit wr_ok, rd_ok;
    bus.msg_wrreq = wr;
    bus.msg_rdreq = rd;
    bus.msg_sclr  = sclr;
    bus.msg_data  = d;
    wr_ok = wr && (mq.size() < MSG_DEPTH);
    rd_ok = rd && (mq.size() > 0);
    tick();
    if (sclr) mq.delete();
    else begin
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(d);
    end
    bus.msg_wrreq = 1'b0;
    bus.msg_rdreq = 1'b0;
    bus.msg_sclr  = 1'b0;
    check_fifo();
  endtask

  initial begin
    logic acc;
    int   sent;
    logic [DATA_WIDTH_DEF-1:0] nxt;

    do_reset(2);
    chk("rst_ready_out", 32'(bus.ready_out), 32'd1);
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_empty", 32'(bus.msg_empty), 32'd1);
    chk("rst_full", 32'(bus.msg_full), 32'd0);
    chk("rst_usedw", 32'(bus.msg_usedw), 32'd0);
    chk("rst_q", bus.msg_q, 32'd0);

    // Back-to-back streaming, one-cycle latency, no bubbles.
    bus.ready_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = DATA_WIDTH_DEF'(i);
      tick();
      chk("lat_valid", 32'(bus.valid_out), 32'd1);
      chk("lat_data", 32'(bus.data_out), 32'(i));
      chk("lat_ready", 32'(bus.ready_out), 32'd1);
    end
    bus.valid_in = 1'b0;
    tick();
    chk("stream_idle_valid", 32'(bus.valid_out), 32'd0);

    // Directed backpressure through the skid register.
    bus.valid_in = 1'b1;
    bus.data_in  = 26'h11;
    tick();
    bus.ready_in = 1'b0;
    bus.data_in  = 26'h12;
    tick();
    chk("bp_ready_fall", 32'(bus.ready_out), 32'd0);
    chk("bp_valid", 32'(bus.valid_out), 32'd1);
    chk("bp_data_hold", 32'(bus.data_out), 32'h11);
    bus.data_in = 26'h13;
    repeat (3) begin
      tick();
      chk("bp_stall_data", 32'(bus.data_out), 32'h11);
      chk("bp_stall_ready", 32'(bus.ready_out), 32'd0);
    end
    bus.ready_in = 1'b1;
    tick();
    chk("bp_ready_rise", 32'(bus.ready_out), 32'd1);
    chk("bp_skid_to_main", 32'(bus.data_out), 32'h12);
    tick();
    chk("bp_resume", 32'(bus.data_out), 32'h13);
    bus.valid_in = 1'b0;
    tick();
    chk("bp_idle", 32'(bus.valid_out), 32'd0);

    // Random valid gaps and random backpressure, then a draining tail.
    sent = 0;
    nxt  = 26'h100;
    for (int c = 0; c < 800 && (sent < 64 || sb.size() > 0 || bus.valid_out); c++) begin
      if (!bus.valid_in && sent < 64 && $urandom_range(0, 3) != 0) begin
        bus.valid_in = 1'b1;
        bus.data_in  = nxt;
      end
      bus.ready_in = (c > 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      acc = bus.valid_in & bus.ready_out;
      tick();
      if (acc) begin
        sent++;
        nxt = nxt + 1'b1;
        bus.valid_in = 1'b0;
      end
    end
    bus.valid_in = 1'b0;
    chk("rand_sent", 32'(sent), 32'd64);
    chk("rand_drained", 32'(sb.size()), 32'd0);

    // FIFO basics.
    msg_cycle(1'b1, 1'b0, 1'b0, {8'h00, MSG_ID_RBB});
    msg_cycle(1'b1, 1'b0, 1'b0, 32'h000A0014);
    msg_cycle(1'b1, 1'b0, 1'b0, 32'h001E0028);
    chk("basic_usedw3", 32'(bus.msg_usedw), 32'd3);
    chk("basic_head", bus.msg_q, 32'h00524242);
    msg_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("basic_pop1", bus.msg_q, 32'h000A0014);
    msg_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("basic_pop2", bus.msg_q, 32'h001E0028);
    msg_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("basic_empty", 32'(bus.msg_empty), 32'd1);
    chk("basic_q0", bus.msg_q, 32'd0);

    // Fill to full, overflow attempt with a concurrent read, then drain.
    for (int i = 0; i < MSG_DEPTH; i++) msg_cycle(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i));
    chk("fill_full", 32'(bus.msg_full), 32'd1);
    chk("fill_usedw_wrap", 32'(bus.msg_usedw), 32'd0);
    msg_cycle(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
    chk("ovf_usedw", 32'(bus.msg_usedw), 32'd255);
    chk("ovf_head", bus.msg_q, 32'h1001);
    while (mq.size() > 0) msg_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    msg_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("udf_empty", 32'(bus.msg_empty), 32'd1);
    chk("udf_usedw", 32'(bus.msg_usedw), 32'd0);

    // Simultaneous read and write, from empty and from one word.
    msg_cycle(1'b1, 1'b1, 1'b0, 32'hAAAA0001);
    chk("rw_empty_usedw", 32'(bus.msg_usedw), 32'd1);
    msg_cycle(1'b1, 1'b1, 1'b0, 32'hAAAA0002);
    chk("rw_one_q", bus.msg_q, 32'hAAAA0002);
    msg_cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Clear beats a same-cycle write.
    for (int i = 0; i < 5; i++) msg_cycle(1'b1, 1'b0, 1'b0, 32'h5000 + 32'(i));
    chk("clr_pre_usedw", 32'(bus.msg_usedw), 32'd5);
    msg_cycle(1'b1, 1'b0, 1'b1, 32'h12345678);
    chk("clr_empty", 32'(bus.msg_empty), 32'd1);
    chk("clr_usedw", 32'(bus.msg_usedw), 32'd0);

    // Reset in the middle of a stall with the skid loaded and messages queued.
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = 26'h200;
    tick();
    bus.data_in  = 26'h201;
    tick();
    chk("mid_skid_full", 32'(bus.ready_out), 32'd0);
    bus.valid_in = 1'b0;
    msg_cycle(1'b1, 1'b0, 1'b0, 32'h77);
    msg_cycle(1'b1, 1'b0, 1'b0, 32'h78);
    do_reset(1);
    chk("mid_rst_valid", 32'(bus.valid_out), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready_out), 32'd1);
    chk("mid_rst_empty", 32'(bus.msg_empty), 32'd1);
    chk("mid_rst_usedw", 32'(bus.msg_usedw), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
